// File: rtl/decode_pkg.sv
// Shared encodings and bit positions for the decode stage and its register file.
// Pipeline word layouts are fixed by the fetch and execute stages on either side.
package decode_pkg;

    localparam int IF_PC_HI    = 63;
    localparam int IF_PC_LO    = 32;
    localparam int IF_INSTR_HI = 31;
    localparam int IF_INSTR_LO = 0;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int SH_HI  = 10;
    localparam int SH_LO  = 6;

    localparam int EX_BR_FLAG     = 70;
    localparam int EX_WB_EN       = 69;
    localparam int EX_WB_ADDR_HI  = 68;
    localparam int EX_WB_ADDR_LO  = 64;
    localparam int EX_TARGET_HI   = 63;
    localparam int EX_TARGET_LO   = 32;
    localparam int EX_WB_DATA_HI  = 31;
    localparam int EX_WB_DATA_LO  = 0;

    localparam int ID_VALID   = 138;
    localparam int ID_OP_HI   = 137;
    localparam int ID_OP_LO   = 134;
    localparam int ID_DEST_HI = 133;
    localparam int ID_DEST_LO = 129;
    localparam int ID_WB_EN   = 128;
    localparam int ID_PC_HI   = 127;
    localparam int ID_PC_LO   = 96;
    localparam int ID_OPA_HI  = 95;
    localparam int ID_OPA_LO  = 64;
    localparam int ID_OPB_HI  = 63;
    localparam int ID_OPB_LO  = 32;
    localparam int ID_IMM_HI  = 31;
    localparam int ID_IMM_LO  = 0;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_LI  = 4'd2,
        OP_SLL = 4'd3,
        OP_SRL = 4'd4,
        OP_AND = 4'd5,
        OP_OR  = 4'd6,
        OP_XOR = 4'd7,
        OP_BR  = 4'd8,
        OP_BNE = 4'd9,
        OP_MOV = 4'd10,
        OP_ADI = 4'd11,
        OP_MUL = 4'd12,
        OP_HLT = 4'd13,
        OP_NOP = 4'd14
    } op_e;

    localparam logic [5:0] OPC_LAST_LEGAL = 6'd14;

    // Field order matches the ID_* bit positions above, MSB first.
    typedef struct packed {
        logic        valid;
        op_e         op;
        logic [4:0]  dest;
        logic        wb_en;
        logic [31:0] pc;
        logic [31:0] opa;
        logic [31:0] opb;
        logic [31:0] imm;
    } id_ex_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// 2-read/1-write register file with write-first bypass; R0 always reads zero.
// Reset loads R[i]=i when INIT_INDEX is nonzero, otherwise all zeros.
module regfile_2r1w #(
    parameter int DATA_W     = 32,
    parameter int REG_CNT    = 32,
    parameter int INIT_INDEX = 1,
    localparam int AW        = $clog2(REG_CNT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     rd_addr_a,
    input  logic [AW-1:0]     rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs_q [REG_CNT];
    logic [DATA_W-1:0] regs_d [REG_CNT];
    logic              wr_live;

    assign wr_live = wr_en && (wr_addr != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_live) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs_q[i] <= (INIT_INDEX != 0) ? DATA_W'(i) : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        if (rd_addr_a != '0) begin
            rd_data_a = (wr_live && wr_addr == rd_addr_a) ? wr_data : regs_q[rd_addr_a];
        end
        if (rd_addr_b != '0) begin
            rd_data_b = (wr_live && wr_addr == rd_addr_b) ? wr_data : regs_q[rd_addr_b];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode: turns IF_ID into a registered ID_EX word, applies EX_WB
// write-back and branch flush, and holds the RUN/HALT state.
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_CNT    = 32,
    parameter int INIT_INDEX = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [63:0]  IF_ID,
    input  logic [70:0]  EX_WB,
    output logic [138:0] ID_EX,
    output logic         halted,
    output logic         illegal_op
);

    typedef enum logic {RUN, HALT} state_e;

    state_e            state_q, state_d;
    id_ex_t            id_ex_q, id_ex_d, dec;
    logic              halted_q, halted_d;
    logic              illegal_q, illegal_d;
    logic [31:0]       instr;
    logic [5:0]        opcode;
    logic [4:0]        rs, rt, rd, shamt;
    logic              legal;
    op_e               op;
    logic [4:0]        addr_a;
    logic [DATA_W-1:0] data_a, data_b;
    logic              unused_target;

    assign instr         = IF_ID[IF_INSTR_HI:IF_INSTR_LO];
    assign opcode        = instr[OPC_HI:OPC_LO];
    assign rs            = instr[RS_HI:RS_LO];
    assign rt            = instr[RT_HI:RT_LO];
    assign rd            = instr[RD_HI:RD_LO];
    assign shamt         = instr[SH_HI:SH_LO];
    assign legal         = (opcode <= OPC_LAST_LEGAL);
    assign op            = legal ? op_e'(opcode[3:0]) : OP_NOP;
    assign addr_a        = (op == OP_SLL || op == OP_SRL) ? rt : rs;
    assign unused_target = ^EX_WB[EX_TARGET_HI:EX_TARGET_LO];

    regfile_2r1w #(
        .DATA_W     (DATA_W),
        .REG_CNT    (REG_CNT),
        .INIT_INDEX (INIT_INDEX)
    ) u_regfile (
        .clk       (clock),
        .rst_n     (reset),
        .rd_addr_a (addr_a),
        .rd_addr_b (rt),
        .rd_data_a (data_a),
        .rd_data_b (data_b),
        .wr_en     (EX_WB[EX_WB_EN]),
        .wr_addr   (EX_WB[EX_WB_ADDR_HI:EX_WB_ADDR_LO]),
        .wr_data   (EX_WB[EX_WB_DATA_HI:EX_WB_DATA_LO])
    );

    // Undefined opcodes leave a NOP carrying only the pc; operands stay zero.
    always_comb begin
        dec       = '0;
        dec.valid = 1'b1;
        dec.op    = op;
        dec.pc    = IF_ID[IF_PC_HI:IF_PC_LO];
        if (legal) begin
            dec.opa = data_a;
            dec.opb = data_b;
            case (op)
                OP_LI:          dec.imm = {21'b0, instr[10:0]};
                OP_SLL, OP_SRL: dec.imm = {27'b0, shamt};
                default:        dec.imm = sext16(instr[15:0]);
            endcase
            case (op)
                OP_ADI:                         dec.dest = rt;
                OP_ADD, OP_SUB, OP_LI, OP_SLL,
                OP_SRL, OP_AND, OP_OR, OP_XOR,
                OP_MOV, OP_MUL:                 dec.dest = rd;
                default:                        dec.dest = '0;
            endcase
            dec.wb_en = (dec.dest != '0);
        end
    end

    always_comb begin
        state_d   = state_q;
        id_ex_d   = '0;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        if (state_q == RUN && !EX_WB[EX_BR_FLAG]) begin
            id_ex_d = dec;
            if (!legal) begin
                illegal_d = 1'b1;
            end
            if (op == OP_HLT) begin
                state_d  = HALT;
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            id_ex_q   <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_ex_q   <= id_ex_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    assign ID_EX      = id_ex_q;
    assign halted     = halted_q;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a driver pushes model predictions, a monitor
// pops one per clock and compares against ID_EX, halted and illegal_op.
module tb_decode_stage;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [63:0]  if_id = '0;
    logic [70:0]  ex_wb = '0;
    logic [138:0] id_ex;
    logic         halted;
    logic         illegal_op;

    always #5 clock = ~clock;

    decode_stage #(
        .DATA_W     (32),
        .REG_CNT    (32),
        .INIT_INDEX (1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .IF_ID      (if_id),
        .EX_WB      (ex_wb),
        .ID_EX      (id_ex),
        .halted     (halted),
        .illegal_op (illegal_op)
    );

    typedef struct {
        logic [138:0] word;
        logic [138:0] mask;
        logic         halted;
        logic         illegal;
        int           seq;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          seq_n = 0;
    logic [31:0] rf_m [32];
    bit          halted_m;
    bit          illegal_m;

    task automatic check(input string name, input logic [138:0] act, input logic [138:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) rf_m[i] = 32'(i);
        halted_m  = 0;
        illegal_m = 0;
    endtask

    function automatic logic [31:0] r_enc(input int op, input int rs, input int rt, input int rd, input int sh);
        logic [5:0] o; logic [4:0] s, t, d, h;
        o = 6'(op); s = 5'(rs); t = 5'(rt); d = 5'(rd); h = 5'(sh);
        return {o, s, t, d, h, 6'b0};
    endfunction

    function automatic logic [31:0] i_enc(input int op, input int rs, input int rt, input int imm);
        logic [5:0] o; logic [4:0] s, t; logic [15:0] m;
        o = 6'(op); s = 5'(rs); t = 5'(rt); m = 16'(imm);
        return {o, s, t, m};
    endfunction

    // One instruction per call: applies inputs at the falling edge and predicts
    // what ID_EX must show after the next rising edge.
    task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input bit br,
                         input bit we, input logic [4:0] wa, input logic [31:0] wd);
        exp_t        e;
        int          opc, rs, rt, rd;
        logic [4:0]  dest;
        logic [31:0] va, vb, imm, tgt;
        bit          wbe;
        @(negedge clock);
        tgt   = $urandom();
        if_id = {pc, instr};
        ex_wb = {br, we, wa, tgt, wd};
        opc = int'(instr[31:26]);
        rs  = int'(instr[25:21]);
        rt  = int'(instr[20:16]);
        rd  = int'(instr[15:11]);
        e.word = '0;
        e.mask = '1;
        if (!halted_m && !br) begin
            if (opc > 14) begin
                illegal_m = 1;
                e.word = {1'b1, 4'd14, 5'd0, 1'b0, pc, 96'b0};
                e.mask = {1'b1, 4'hF, 5'h1F, 1'b1, 32'hFFFF_FFFF, 96'b0};
            end else begin
                va = rf_m[(opc == 3 || opc == 4) ? rt : rs];
                vb = rf_m[rt];
                if (we && wa != 0 && int'(wa) == ((opc == 3 || opc == 4) ? rt : rs)) va = wd;
                if (we && wa != 0 && int'(wa) == rt) vb = wd;
                if (opc == 2)                 imm = {21'b0, instr[10:0]};
                else if (opc == 3 || opc == 4) imm = {27'b0, instr[10:6]};
                else                          imm = {{16{instr[15]}}, instr[15:0]};
                if (opc == 11)                                        dest = 5'(rt);
                else if (opc <= 7 || opc == 10 || opc == 12)          dest = 5'(rd);
                else                                                  dest = 5'd0;
                wbe = (dest != 0);
                e.word = {1'b1, 4'(opc), dest, wbe, pc, va, vb, imm};
                if (opc == 13) halted_m = 1;
            end
        end
        if (we && wa != 0) rf_m[wa] = wd;
        e.halted  = halted_m;
        e.illegal = illegal_m;
        e.seq     = seq_n++;
        sb_q.push_back(e);
    endtask

    task automatic drive_random(input int n, input bit allow_illegal, inout logic [31:0] pc);
        logic [31:0] r, wd;
        logic [5:0]  op6;
        logic [4:0]  wa;
        int          op;
        bit          br, we;
        for (int i = 0; i < n; i++) begin
            br = ($urandom_range(0, 9) == 0);
            we = ($urandom_range(0, 2) != 0);
            r  = $urandom();
            wd = $urandom();
            wa = 5'($urandom_range(0, 31));
            op = $urandom_range(0, 14);
            if (op == 13) op = 14;
            if (allow_illegal && !br && $urandom_range(0, 7) == 0) op = $urandom_range(15, 63);
            op6 = 6'(op);
            drive(pc, {op6, r[25:0]}, br, we, wa, wd);
            pc = pc + 1;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check($sformatf("id_ex#%0d", e.seq), id_ex & e.mask, e.word & e.mask);
                check($sformatf("halted#%0d", e.seq), 139'(halted), 139'(e.halted));
                check($sformatf("illegal#%0d", e.seq), 139'(illegal_op), 139'(e.illegal));
            end
        end
    end

    initial begin : stim
        logic [31:0] pc;
        model_reset();
        #12;
        check("rst_id_ex", id_ex, '0);
        check("rst_halted", 139'(halted), '0);
        check("rst_illegal", 139'(illegal_op), '0);
        @(negedge clock);
        reset = 1'b1;

        drive(0,  r_enc(0, 2, 1, 15, 0), 0, 0, 0, 0);
        drive(2,  32'h0800_880F, 0, 0, 0, 0);
        drive(3,  r_enc(3, 0, 1, 18, 3), 0, 0, 0, 0);
        drive(4,  r_enc(0, 2, 1, 15, 0), 0, 1, 5'd2, 32'h55);
        drive(5,  r_enc(0, 2, 1, 15, 0), 0, 0, 0, 0);
        drive(9,  r_enc(1, 3, 4, 7, 0),  1, 0, 0, 0);
        drive(14, i_enc(9, 3, 4, 6),     0, 0, 0, 0);
        drive(15, i_enc(11, 0, 26, 3),   0, 1, 5'd0, 32'hABCD);
        drive(16, r_enc(10, 0, 0, 5, 0), 0, 0, 0, 0);
        drive(17, i_enc(11, 4, 0, -2),   1, 1, 5'd7, 32'h7777);
        drive(18, r_enc(5, 7, 7, 9, 0),  0, 0, 0, 0);

        pc = 32'd100;
        drive_random(300, 0, pc);

        drive(19, r_enc(13, 0, 0, 0, 0), 0, 0, 0, 0);
        drive(20, r_enc(14, 0, 0, 0, 0), 0, 1, 5'd3, 32'h1234);
        drive(21, r_enc(0, 3, 3, 8, 0),  0, 0, 0, 0);
        drive(22, r_enc(2, 0, 0, 9, 5),  1, 0, 0, 0);

        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("midrst_id_ex", id_ex, '0);
        check("midrst_halted", 139'(halted), '0);
        check("midrst_illegal", 139'(illegal_op), '0);
        model_reset();
        if_id = '0;
        ex_wb = '0;
        @(negedge clock);
        reset = 1'b1;

        drive(30, {6'h3F, 26'h155_5555}, 0, 0, 0, 0);
        drive(31, r_enc(0, 4, 5, 6, 0),  0, 0, 0, 0);
        drive(32, r_enc(6, 1, 2, 0, 0),  0, 0, 0, 0);

        pc = 32'd400;
        drive_random(300, 1, pc);

        drive(40, r_enc(13, 0, 0, 0, 0), 1, 1, 5'd4, 32'h99);
        drive(41, r_enc(0, 4, 1, 2, 0),  0, 0, 0, 0);

        repeat (3) @(posedge clock);
        #2;
        check("sb_drain", 139'(sb_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
